// File: rtl/ldm_ctrl_pkg.sv
// ldm_ctrl_pkg: shared constants, state/mode encodings and popcount helper for the LDM/STM sequencer.
package ldm_ctrl_pkg;
   localparam int WORD_BYTES = 4;
   localparam logic [3:0] REG_PC = 4'd15;
   typedef enum logic {IDLE, BUSY} state_t;
   // Mode code is {P, U}
   typedef enum logic [1:0] {DA = 2'b00, IA = 2'b01, DB = 2'b10, IB = 2'b11} mode_t;
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      popcount16 = '0;
      for (int i = 0; i < 16; i++) popcount16 = popcount16 + {4'd0, v[i]};
   endfunction
endpackage

// File: rtl/ldm_stm_ctrl_if.sv
// ldm_stm_ctrl_if: instruction-in / transfer-out bundle of the LDM/STM sequencer.
interface ldm_stm_ctrl_if #(parameter int ADDR_W = 32);
   logic              en;
   logic              i_ldm_vld;
   logic              i_ldm_p;
   logic              i_ldm_u;
   logic              i_ldm_l;
   logic [15:0]       i_reglist;
   logic              o_ldm_hold;
   logic              o_ldm_flushreq;
   logic [ADDR_W-1:0] o_ldm_offset;
   logic              o_ldm_mem_vld;
   logic [3:0]        o_ldm_reg_code;
   modport master (
      output en, i_ldm_vld, i_ldm_p, i_ldm_u, i_ldm_l, i_reglist,
      input  o_ldm_hold, o_ldm_flushreq, o_ldm_offset, o_ldm_mem_vld, o_ldm_reg_code
   );
   modport slave (
      input  en, i_ldm_vld, i_ldm_p, i_ldm_u, i_ldm_l, i_reglist,
      output o_ldm_hold, o_ldm_flushreq, o_ldm_offset, o_ldm_mem_vld, o_ldm_reg_code
   );
endinterface

// File: rtl/ldm_prio_enc.sv
// ldm_prio_enc: 16-bit lowest-set-bit encoder (index + any-bit-set).
module ldm_prio_enc (
   input  logic [15:0] list,
   output logic [3:0]  idx,
   output logic        vld
);
   always_comb begin
      idx = '0;
      for (int i = 15; i >= 0; i--) if (list[i]) idx = 4'(i);
   end
   assign vld = |list;
endmodule

// File: rtl/ldm_stm_ctrl.sv
// ldm_stm_ctrl: LDM/STM micro-sequencer, one register transfer per enabled cycle.
// Define LDM_CTRL_EMPTY_LIST_EN for ARMv4 empty-list behaviour (single r15 transfer, n = 16 offsets).
module ldm_stm_ctrl
   import ldm_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input logic           clk,
   input logic           rst,
   ldm_stm_ctrl_if.slave bus
);
   state_t            state_q, state_d;
   logic [15:0]       rem_q, rem_d;
   logic [ADDR_W-1:0] off_q, off_d;
   logic              l_q, l_d;
   logic [15:0]       in_list, act_list, rest;
   logic [4:0]        n_in;
   logic [ADDR_W-1:0] step, n_bytes, start_off, cur_off;
   logic [3:0]        idx;
   logic              any, accept, busy, show, issue, cur_l;
   mode_t             mode;
`ifdef LDM_CTRL_EMPTY_LIST_EN
   assign in_list = (bus.i_reglist == '0) ? 16'h8000 : bus.i_reglist;
   assign n_in    = (bus.i_reglist == '0) ? 5'd16 : popcount16(bus.i_reglist);
   assign accept  = (state_q == IDLE) & bus.en & bus.i_ldm_vld;
`else
   assign in_list = bus.i_reglist;
   assign n_in    = popcount16(bus.i_reglist);
   assign accept  = (state_q == IDLE) & bus.en & bus.i_ldm_vld & (bus.i_reglist != '0);
`endif
   assign busy      = state_q == BUSY;
   assign mode      = mode_t'({bus.i_ldm_p, bus.i_ldm_u});
   assign step      = ADDR_W'(WORD_BYTES);
   assign n_bytes   = ADDR_W'(n_in) << 2;
   assign start_off = (mode == IA) ? '0 : (mode == IB) ? step : (mode == DA) ? step - n_bytes : -n_bytes;
   assign act_list  = busy ? rem_q : in_list;
   ldm_prio_enc u_enc (.list(act_list), .idx(idx), .vld(any));
   assign rest    = act_list & ~(16'd1 << idx);
   assign cur_off = busy ? off_q : start_off;
   assign cur_l   = busy ? l_q : bus.i_ldm_l;
   assign show    = busy | accept;
   assign issue   = bus.en & any & show;
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      off_d   = off_q;
      l_d     = l_q;
      if (issue) begin
         state_d = (rest != '0) ? BUSY : IDLE;
         rem_d   = rest;
         off_d   = (rest != '0) ? cur_off + step : '0;
         l_d     = cur_l;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         off_q   <= '0;
         l_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         off_q   <= off_d;
         l_q     <= l_d;
      end
   end
   // Outputs are forced low for the whole time reset is asserted, even on an accept cycle
   assign bus.o_ldm_mem_vld  = !rst & issue;
   assign bus.o_ldm_reg_code = (!rst & show) ? idx : '0;
   assign bus.o_ldm_offset   = (!rst & show) ? cur_off : '0;
   assign bus.o_ldm_hold     = !rst & ((issue & (rest != '0)) | (busy & !bus.en));
   assign bus.o_ldm_flushreq = bus.o_ldm_mem_vld & cur_l & (idx == REG_PC);
endmodule

// File: tb/tb_ldm_stm_ctrl.sv
// tb_ldm_stm_ctrl: directed vector table, reset corner sequence and randomized check against a queue model.
module tb_ldm_stm_ctrl;
   typedef struct {
      logic        en, vld, p, u, l;
      logic [15:0] list;
      logic        mv, hold, fl;
      logic [3:0]  rc;
      logic [31:0] off;
   } vec_t;
   typedef struct {
      logic [3:0]  r;
      logic [31:0] o;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   vec_t tbl[$];
   ent_t q[$];
   logic ml;
   always #5 clk = ~clk;
   ldm_stm_ctrl_if #(.ADDR_W(32)) bus ();
   ldm_stm_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   function automatic vec_t mk(logic en, logic vld, logic p, logic u, logic l, logic [15:0] list,
                               logic mv, logic hold, logic fl, logic [3:0] rc, logic [31:0] off);
      vec_t v;
      v.en = en; v.vld = vld; v.p = p; v.u = u; v.l = l; v.list = list;
      v.mv = mv; v.hold = hold; v.fl = fl; v.rc = rc; v.off = off;
      return v;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask
   task automatic drive(vec_t v);
      bus.en = v.en; bus.i_ldm_vld = v.vld; bus.i_ldm_p = v.p; bus.i_ldm_u = v.u;
      bus.i_ldm_l = v.l; bus.i_reglist = v.list;
   endtask
   task automatic check_outs(string tag, vec_t v);
      chk({tag, ".mem_vld"}, 32'(bus.o_ldm_mem_vld), 32'(v.mv));
      chk({tag, ".hold"}, 32'(bus.o_ldm_hold), 32'(v.hold));
      chk({tag, ".flush"}, 32'(bus.o_ldm_flushreq), 32'(v.fl));
      chk({tag, ".reg"}, 32'(bus.o_ldm_reg_code), 32'(v.rc));
      chk({tag, ".off"}, bus.o_ldm_offset, v.off);
   endtask
   task automatic apply(string tag, vec_t v);
      drive(v);
      #3;
      check_outs(tag, v);
      @(posedge clk);
      #1;
   endtask
   task automatic model_build(logic p, logic u, logic l, logic [15:0] list);
      logic [15:0] eff;
      logic [31:0] nb, base;
      int i;
      eff = list;
      nb = 32'($countones(list)) * 4;
      if (list == 16'h0) begin
         eff = 16'h8000;
         nb = 64;
      end
      case ({p, u})
         2'b01:   base = 32'd0;
         2'b11:   base = 32'd4;
         2'b00:   base = 32'd4 - nb;
         default: base = 32'd0 - nb;
      endcase
      i = 0;
      for (int k = 0; k < 16; k++) if (eff[k]) begin
         q.push_back('{r: 4'(k), o: base + 32'(4 * i)});
         i++;
      end
      ml = l;
   endtask
   initial begin
      vec_t v;
      bit empty_en;
`ifdef LDM_CTRL_EMPTY_LIST_EN
      empty_en = 1'b1;
`else
      empty_en = 1'b0;
`endif
      tbl.push_back(mk(1,1,0,1,0,16'h0005, 1,1,0,0,32'h0));
      tbl.push_back(mk(1,0,0,1,0,16'h0000, 1,0,0,2,32'h4));
      tbl.push_back(mk(1,1,1,0,1,16'h8003, 1,1,0,0,32'hFFFFFFF4));
      tbl.push_back(mk(1,0,0,0,0,16'h0000, 1,1,0,1,32'hFFFFFFF8));
      tbl.push_back(mk(1,0,0,0,0,16'h0000, 1,0,1,15,32'hFFFFFFFC));
      tbl.push_back(mk(1,0,0,0,0,16'h0000, 0,0,0,0,32'h0));
      tbl.push_back(mk(1,1,0,0,0,16'h0006, 1,1,0,1,32'hFFFFFFFC));
      tbl.push_back(mk(1,1,1,1,1,16'h8000, 1,0,0,2,32'h0));
      tbl.push_back(mk(1,1,1,1,0,16'h0010, 1,0,0,4,32'h4));
      tbl.push_back(mk(0,1,0,1,0,16'h00F0, 0,0,0,0,32'h0));
      tbl.push_back(mk(1,1,0,1,0,16'h00F0, 1,1,0,4,32'h0));
      tbl.push_back(mk(0,0,0,0,0,16'h0000, 0,1,0,5,32'h4));
      tbl.push_back(mk(0,1,0,1,1,16'h0001, 0,1,0,5,32'h4));
      tbl.push_back(mk(1,0,0,0,0,16'h0000, 1,1,0,5,32'h4));
      tbl.push_back(mk(1,0,0,0,0,16'h0000, 1,1,0,6,32'h8));
      tbl.push_back(mk(1,0,0,0,0,16'h0000, 1,0,0,7,32'hC));
      tbl.push_back(mk(1,1,1,1,1,16'h8000, 1,0,1,15,32'h4));
      tbl.push_back(mk(1,1,0,1,0,16'h8000, 1,0,0,15,32'h0));
`ifdef LDM_CTRL_EMPTY_LIST_EN
      tbl.push_back(mk(1,1,1,0,1,16'h0000, 1,0,1,15,32'hFFFFFFC0));
      tbl.push_back(mk(1,1,0,0,0,16'h0000, 1,0,0,15,32'hFFFFFFC4));
      tbl.push_back(mk(1,1,0,1,1,16'h0000, 1,0,1,15,32'h0));
`else
      tbl.push_back(mk(1,1,1,0,1,16'h0000, 0,0,0,0,32'h0));
      tbl.push_back(mk(1,1,0,1,0,16'h0000, 0,0,0,0,32'h0));
`endif
      tbl.push_back(mk(1,1,0,1,0,16'h0001, 1,0,0,0,32'h0));
      tbl.push_back(mk(1,1,1,0,0,16'hFFFF, 1,1,0,0,32'hFFFFFFC0));
      tbl.push_back(mk(1,0,0,0,0,16'h0000, 1,1,0,1,32'hFFFFFFC4));
      // Reset: outputs low even with an acceptable instruction presented
      drive(mk(1,1,0,1,1,16'hFFFF, 0,0,0,0,0));
      #3;
      check_outs("reset", mk(1,1,0,1,1,16'hFFFF, 0,0,0,0,0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);
      // Reset in the middle of the 0xFFFF sequence
      drive(mk(1,0,0,0,0,16'h0000, 0,0,0,0,0));
      rst = 1'b1;
      #1;
      check_outs("rst_busy", mk(1,0,0,0,0,16'h0000, 0,0,0,0,0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply("post_rst_ia", mk(1,1,0,1,0,16'h0001, 1,0,0,0,32'h0));
      apply("post_rst_idle", mk(1,0,0,0,0,16'h0000, 0,0,0,0,32'h0));
      q.delete();
      for (int c = 0; c < 600; c++) begin
         v.en = ($urandom_range(0, 4) != 0);
         v.vld = 1'($urandom_range(0, 1));
         v.p = 1'($urandom_range(0, 1));
         v.u = 1'($urandom_range(0, 1));
         v.l = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       v.list = 16'($urandom);
            1:       v.list = 16'($urandom & $urandom & $urandom);
            2:       v.list = 16'h8000 | 16'(1 << $urandom_range(0, 14));
            default: v.list = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'h8000;
         endcase
         if (q.size() == 0 && v.en && v.vld && (v.list != 16'h0 || empty_en)) model_build(v.p, v.u, v.l, v.list);
         if (q.size() == 0) begin
            v.mv = 0; v.hold = 0; v.fl = 0; v.rc = 0; v.off = 0;
         end else begin
            v.mv = v.en;
            v.hold = v.en ? (q.size() > 1) : 1'b1;
            v.fl = v.en & ml & (q[0].r == 4'd15);
            v.rc = q[0].r;
            v.off = q[0].o;
         end
         apply($sformatf("rnd%0d", c), v);
         if (v.en && q.size() > 0) void'(q.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
